// File: rtl/msk_demux_buf.sv
// Masked 1-to-2 demultiplexer with one registered share buffer per output channel.
// Optional precharge-on-drain behaviour is enabled by defining MSK_DEMUX_PRECHARGE_EN.
module msk_demux_buf #(
  parameter int d     = 1,
  parameter int count = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [count*d-1:0] in_data,
  output logic               out0_valid,
  input  logic               out0_ready,
  output logic [count*d-1:0] out0_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic [count*d-1:0] out1_data
);

  localparam int W = count * d;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state  [2];
  logic [W-1:0] data_q [2];
  logic [1:0]   drain;
  logic [1:0]   room;
  logic [1:0]   load;
  logic         accept;

  assign drain[0] = (state[0] == FULL) & out0_ready;
  assign drain[1] = (state[1] == FULL) & out1_ready;

`ifdef MSK_DEMUX_PRECHARGE_EN
  // A draining channel is precharged to zero this edge, so it cannot also take new data.
  assign room[0] = (state[0] == EMPTY);
  assign room[1] = (state[1] == EMPTY);
`else
  assign room[0] = (state[0] == EMPTY) | drain[0];
  assign room[1] = (state[1] == EMPTY) | drain[1];
`endif

  // Steering depends only on the non-sensitive select and channel status, never on shares.
  assign in_ready = ~rst & (sel ? room[1] : room[0]);
  assign accept   = in_valid & in_ready;
  assign load[0]  = accept & ~sel;
  assign load[1]  = accept &  sel;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        state[k]  <= EMPTY;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (load[k]) begin
          state[k]  <= FULL;
          data_q[k] <= in_data;
        end else if (drain[k]) begin
          state[k]  <= EMPTY;
`ifdef MSK_DEMUX_PRECHARGE_EN
          data_q[k] <= '0;
`endif
        end
      end
    end
  end

  assign out0_valid = (state[0] == FULL);
  assign out1_valid = (state[1] == FULL);
  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];

endmodule

// File: tb/tb_msk_demux_buf.sv
// Self-checking bench for msk_demux_buf (d=2, count=3): vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_msk_demux_buf;

  localparam int D = 2;
  localparam int C = 3;
  localparam int W = D * C;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out0_valid, out0_ready;
  logic [W-1:0] out0_data;
  logic         out1_valid, out1_ready;
  logic [W-1:0] out1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msk_demux_buf #(.d(D), .count(C)) dut (
    .clk(clk), .rst(rst), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
  );

`ifdef MSK_DEMUX_PRECHARGE_EN
  localparam bit PRECHARGE = 1'b1;
`else
  localparam bit PRECHARGE = 1'b0;
`endif

  // Value a channel shows after its sharing has been consumed.
  function automatic logic [W-1:0] drained(input logic [W-1:0] v);
    return PRECHARGE ? '0 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         sel, vld;
    logic [W-1:0] data;
    logic         r0, r1;
    logic         exp_rdy;
    logic         exp_v0;
    logic [W-1:0] exp_d0;
    logic         exp_v1;
    logic [W-1:0] exp_d1;
  } vec_t;

  vec_t vecs[7];

  // Reference model: each channel is a queue of capacity one plus the value it displays.
  logic [W-1:0] mq [2][$];
  logic [W-1:0] shown [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      shown[k] = '0;
    end
  endtask

  function automatic logic model_ready(input logic s, input logic r0, input logic r1);
    int  k;
    logic consumer;
    k = s ? 1 : 0;
    consumer = s ? r1 : r0;
    if (mq[k].size() == 0) return 1'b1;
    return !PRECHARGE && consumer;
  endfunction

  task automatic model_edge(input logic s, input logic v, input logic [W-1:0] dat,
                            input logic r0, input logic r1);
    logic acc;
    logic [W-1:0] popped;
    acc = v && model_ready(s, r0, r1);
    for (int k = 0; k < 2; k++) begin
      if (mq[k].size() != 0 && ((k == 0) ? r0 : r1)) begin
        popped = mq[k].pop_front();
        shown[k] = drained(popped);
      end
    end
    if (acc) begin
      mq[s ? 1 : 0].push_back(dat);
      shown[s ? 1 : 0] = dat;
    end
  endtask

  logic         exp_v_seq [6];
  logic [W-1:0] exp_d_seq [6];

  initial begin
    int idx;
    logic acc;
    logic pend;

    vecs[0] = '{1'b0, 1'b1, 6'h2D, 1'b1, 1'b0, 1'b1, 1'b1, 6'h2D, 1'b0, 6'h00};
    vecs[1] = '{1'b1, 1'b1, 6'h15, 1'b1, 1'b0, 1'b1, 1'b0, drained(6'h2D), 1'b1, 6'h15};
    vecs[2] = '{1'b1, 1'b1, 6'h3A, 1'b0, 1'b0, 1'b0, 1'b0, drained(6'h2D), 1'b1, 6'h15};
    vecs[3] = '{1'b0, 1'b1, 6'h3A, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3A, 1'b1, 6'h15};
    vecs[4] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 6'h3A, 1'b0, drained(6'h15)};
    vecs[5] = '{1'b1, 1'b1, 6'h0F, 1'b1, 1'b0, 1'b1, 1'b0, drained(6'h3A), 1'b1, 6'h0F};
    vecs[6] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, drained(6'h3A), 1'b0, drained(6'h0F)};

    // Reset state.
    rst = 1'b1; sel = 1'b0; in_valid = 1'b1; in_data = 6'h3F;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    check("reset_v0", out0_valid, 0);
    check("reset_v1", out1_valid, 0);
    check("reset_d0", out0_data, 0);
    check("reset_d1", out1_data, 0);
    check("reset_rdy", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("post_reset_rdy", in_ready, 1);

    // Vector table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sel = vecs[i].sel; in_valid = vecs[i].vld; in_data = vecs[i].data;
      out0_ready = vecs[i].r0; out1_ready = vecs[i].r1;
      #1 check($sformatf("vec%0d_rdy", i), in_ready, vecs[i].exp_rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_v0", i), out0_valid, vecs[i].exp_v0);
      check($sformatf("vec%0d_d0", i), out0_data, vecs[i].exp_d0);
      check($sformatf("vec%0d_v1", i), out1_valid, vecs[i].exp_v1);
      check($sformatf("vec%0d_d1", i), out1_data, vecs[i].exp_d1);
    end

    // Continuous stream 01,02,03 to channel 0 with an always-ready consumer.
    if (PRECHARGE) begin
      exp_v_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_d_seq = '{6'h01, 6'h00, 6'h02, 6'h00, 6'h03, 6'h00};
    end else begin
      exp_v_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_d_seq = '{6'h01, 6'h02, 6'h03, 6'h03, 6'h03, 6'h03};
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      sel = 1'b0; out0_ready = 1'b1; out1_ready = 1'b0;
      in_valid = (idx < 3);
      in_data  = W'(idx + 1);
      #1 acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      check($sformatf("stream%0d_v0", c), out0_valid, exp_v_seq[c]);
      check($sformatf("stream%0d_d0", c), out0_data, exp_d_seq[c]);
    end

    // Fill both channels, then reset asynchronously mid-cycle.
    @(negedge clk);
    sel = 1'b0; in_valid = 1'b1; in_data = 6'h11; out0_ready = 1'b0; out1_ready = 1'b0;
    @(negedge clk);
    sel = 1'b1; in_data = 6'h22;
    @(posedge clk); #1;
    check("prefill_v0", out0_valid, 1);
    check("prefill_v1", out1_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_v0", out0_valid, 0);
    check("async_v1", out1_valid, 0);
    check("async_d0", out0_data, 0);
    check("async_d1", out1_data, 0);
    check("async_rdy", in_ready, 0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_rdy", in_ready, 0);
    check("hold_v1", out1_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("release_rdy", in_ready, 1);
    @(posedge clk); #1;
    check("release_load_v1", out1_valid, 1);
    check("release_load_d1", out1_data, 6'h22);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the reference model.
    pend = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!pend) begin
        sel      = 1'($urandom_range(0, 1));
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_rdy", in_ready, model_ready(sel, out0_ready, out1_ready));
      check("rnd_v0", out0_valid, mq[0].size() != 0);
      check("rnd_v1", out1_valid, mq[1].size() != 0);
      check("rnd_d0", out0_data, shown[0]);
      check("rnd_d1", out1_data, shown[1]);
      pend = in_valid && !model_ready(sel, out0_ready, out1_ready);
      @(posedge clk);
      model_edge(sel, in_valid, in_data, out0_ready, out1_ready);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
